// File: rtl/rom_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter_pkg
//   Shared definitions for the ROM access arbiter and its round-robin picker:
//   FSM state encoding and requester identifiers.
// -----------------------------------------------------------------------------
package rom_access_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Requester ids; also the bit position of each requester in REQ/GNT vectors.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage : rom_access_arbiter_pkg

// File: rtl/rom_access_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Combinational two-way round-robin picker. The parent owns the LAST
//   register and feeds it back here.
// Ports
//   REQ[1:0]  in   request vector, bit REQ_IF / REQ_LS
//   LAST      in   id of the most recently granted requester
//   EN        in   grant permission; no grant when low
//   GNT[1:0]  out  one-hot grant (all zero when no grant)
//   SEL       out  id of the granted requester (meaningful only when |GNT)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import rom_access_arbiter_pkg::*;
(
  input  logic [1:0] REQ,
  input  logic       LAST,
  input  logic       EN,
  output logic [1:0] GNT,
  output logic       SEL
);

  always_comb begin
    GNT = 2'b00;
    SEL = REQ_IF;
    if (EN) begin
      case (REQ)
        2'b01: begin
          GNT = 2'b01;
          SEL = REQ_IF;
        end
        2'b10: begin
          GNT = 2'b10;
          SEL = REQ_LS;
        end
        2'b11: begin
          // Contention: the requester that did not win last time goes first.
          SEL = ~LAST;
          GNT = (~LAST == REQ_LS) ? 2'b10 : 2'b01;
        end
        default: begin
          GNT = 2'b00;
          SEL = REQ_IF;
        end
      endcase
    end
  end

endmodule : rr_arbiter2

// File: rtl/rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter
//   Shares one synchronous-read ROM between instruction fetch (IF) and the
//   load/store unit (LS). Round-robin arbitration, one ROM access per cycle,
//   1-cycle response latency, and a one-entry hold register that keeps the
//   response stable while the owner withholds RREADY.
// Ports
//   CLK, RST_N                   clock, asynchronous active-low reset
//   IF_REQ/IF_ADDR/IF_GNT        IF request channel (GNT combinational)
//   IF_RVALID/IF_RREADY/IF_RDATA IF response channel (RDATA 0 when not valid)
//   LS_*                         same set for the load/store unit
//   ROM_ENABLE/ROM_ADDR          ROM read strobe and address (ADDR 0 when idle)
//   ROM_DATA                     ROM registered read data, valid next cycle
// -----------------------------------------------------------------------------
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_DEPTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IF_REQ,
  input  logic [ADDR_DEPTH-1:0] IF_ADDR,
  output logic                  IF_GNT,
  output logic                  IF_RVALID,
  input  logic                  IF_RREADY,
  output logic [WORD_SIZE-1:0]  IF_RDATA,
  input  logic                  LS_REQ,
  input  logic [ADDR_DEPTH-1:0] LS_ADDR,
  output logic                  LS_GNT,
  output logic                  LS_RVALID,
  input  logic                  LS_RREADY,
  output logic [WORD_SIZE-1:0]  LS_RDATA,
  output logic                  ROM_ENABLE,
  output logic [ADDR_DEPTH-1:0] ROM_ADDR,
  input  logic [WORD_SIZE-1:0]  ROM_DATA
);

  state_t                state_p1, state_nxt;
  logic                  owner_p1, owner_nxt;
  logic                  last_p1,  last_nxt;
  logic [WORD_SIZE-1:0]  hold_p1,  hold_nxt;

  logic                  vld_p1;
  logic                  owner_rready;
  logic                  free;
  logic                  arb_en;
  logic [1:0]            gnt;
  logic                  sel;
  logic                  accept;
  logic [WORD_SIZE-1:0]  resp_data;

  // ---- Stage 0: issue decision and ROM request ----
  assign vld_p1       = (state_p1 != IDLE);
  assign owner_rready = (owner_p1 == REQ_LS) ? LS_RREADY : IF_RREADY;
  // A new access may issue when nothing is outstanding or the outstanding
  // response is being consumed this very cycle.
  assign free         = (state_p1 == IDLE) | (vld_p1 & owner_rready);
  assign arb_en       = free & RST_N;

  rr_arbiter2 u_rr (
    .REQ  ({LS_REQ, IF_REQ}),
    .LAST (last_p1),
    .EN   (arb_en),
    .GNT  (gnt),
    .SEL  (sel)
  );

  assign accept     = |gnt;
  assign IF_GNT     = gnt[REQ_IF];
  assign LS_GNT     = gnt[REQ_LS];
  assign ROM_ENABLE = accept;
  assign ROM_ADDR   = accept ? ((sel == REQ_LS) ? LS_ADDR : IF_ADDR)
                             : '0;

  // ---- Stage 1: response from ROM or hold register ----
  assign resp_data = (state_p1 == HOLD) ? hold_p1 : ROM_DATA;
  assign IF_RVALID = vld_p1 & (owner_p1 == REQ_IF);
  assign LS_RVALID = vld_p1 & (owner_p1 == REQ_LS);
  assign IF_RDATA  = IF_RVALID ? resp_data : '0;
  assign LS_RDATA  = LS_RVALID ? resp_data : '0;

  always_comb begin
    state_nxt = state_p1;
    owner_nxt = owner_p1;
    last_nxt  = accept ? sel : last_p1;
    hold_nxt  = hold_p1;
    case (state_p1)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          owner_nxt = sel;
        end
      end
      BUSY, HOLD: begin
        if (owner_rready) begin
          if (accept) begin
            state_nxt = BUSY;
            owner_nxt = sel;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          // ROM output is only valid for one cycle; capture it on the first
          // stalled cycle and replay it from the hold register afterwards.
          if (state_p1 == BUSY) begin
            hold_nxt = ROM_DATA;
          end
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p1 <= IDLE;
      owner_p1 <= REQ_LS;
      last_p1  <= REQ_LS;
      hold_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      owner_p1 <= owner_nxt;
      last_p1  <= last_nxt;
      hold_p1  <= hold_nxt;
    end
  end

endmodule : rom_access_arbiter

// File: tb/tb_rom_access_arbiter.sv
module tb_rom_access_arbiter;

  localparam int WS = 32;
  localparam int AD = 10;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IF_REQ, IF_RREADY, IF_GNT, IF_RVALID;
  logic [AD-1:0] IF_ADDR;
  logic [WS-1:0] IF_RDATA;
  logic          LS_REQ, LS_RREADY, LS_GNT, LS_RVALID;
  logic [AD-1:0] LS_ADDR;
  logic [WS-1:0] LS_RDATA;
  logic          ROM_ENABLE;
  logic [AD-1:0] ROM_ADDR;
  logic [WS-1:0] ROM_DATA;

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  // ROM model: mem[a] = 32'hA500_0000 | a, registered read, 0 when not enabled.
  always_ff @(posedge CLK) begin
    ROM_DATA <= ROM_ENABLE ? (32'hA500_0000 | {22'h0, ROM_ADDR}) : 32'h0;
  end

  rom_access_arbiter #(.WORD_SIZE(WS), .ADDR_DEPTH(AD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
    .IF_RVALID(IF_RVALID), .IF_RREADY(IF_RREADY), .IF_RDATA(IF_RDATA),
    .LS_REQ(LS_REQ), .LS_ADDR(LS_ADDR), .LS_GNT(LS_GNT),
    .LS_RVALID(LS_RVALID), .LS_RREADY(LS_RREADY), .LS_RDATA(LS_RDATA),
    .ROM_ENABLE(ROM_ENABLE), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Move to the next negedge (inputs are changed there, checks follow at +1).
  task automatic nxt();
    @(negedge CLK);
  endtask

  int if_n, ls_n;
  logic          exp_if;
  logic          prev_if;
  logic [31:0]   prev_data;

  initial begin
    RST_N = 1'b0;
    IF_REQ = 0; LS_REQ = 0; IF_ADDR = '0; LS_ADDR = '0;
    IF_RREADY = 1; LS_RREADY = 1;

    // Reset state: requests are ignored while RST_N is low.
    nxt(); IF_REQ = 1; LS_REQ = 1; #1;
    chk("rst_if_gnt", {31'h0, IF_GNT}, 32'h0);
    chk("rst_ls_gnt", {31'h0, LS_GNT}, 32'h0);
    chk("rst_rom_en", {31'h0, ROM_ENABLE}, 32'h0);
    chk("rst_if_rvalid", {31'h0, IF_RVALID}, 32'h0);
    chk("rst_ls_rvalid", {31'h0, LS_RVALID}, 32'h0);
    chk("rst_if_rdata", IF_RDATA, 32'h0);
    chk("rst_ls_rdata", LS_RDATA, 32'h0);

    // Test 4: idle after reset.
    nxt(); IF_REQ = 0; LS_REQ = 0; RST_N = 1; #1;
    chk("idle_rom_en", {31'h0, ROM_ENABLE}, 32'h0);
    chk("idle_rom_addr", {22'h0, ROM_ADDR}, 32'h0);
    nxt(); #1;
    chk("idle_if_rvalid", {31'h0, IF_RVALID}, 32'h0);
    chk("idle_ls_rvalid", {31'h0, LS_RVALID}, 32'h0);
    chk("idle_if_rdata", IF_RDATA, 32'h0);
    chk("idle_ls_rdata", LS_RDATA, 32'h0);

    // Test 1: single IF read of 0x010.
    nxt(); IF_REQ = 1; IF_ADDR = 10'h010; #1;
    chk("t1_if_gnt", {31'h0, IF_GNT}, 32'h1);
    chk("t1_ls_gnt", {31'h0, LS_GNT}, 32'h0);
    chk("t1_rom_en", {31'h0, ROM_ENABLE}, 32'h1);
    chk("t1_rom_addr", {22'h0, ROM_ADDR}, 32'h010);
    nxt(); IF_REQ = 0; #1;
    chk("t1_if_rvalid", {31'h0, IF_RVALID}, 32'h1);
    chk("t1_if_rdata", IF_RDATA, 32'hA500_0010);
    chk("t1_ls_rvalid", {31'h0, LS_RVALID}, 32'h0);
    chk("t1_ls_rdata", LS_RDATA, 32'h0);
    chk("t1_rom_en_off", {31'h0, ROM_ENABLE}, 32'h0);
    nxt(); #1;
    chk("t1_idle_rvalid", {31'h0, IF_RVALID}, 32'h0);

    // Test 6: only LS requests for 4 cycles, 0x100..0x103.
    for (int k = 0; k < 4; k++) begin
      nxt(); LS_REQ = 1; LS_ADDR = 10'h100 + 10'(k); #1;
      chk("t6_ls_gnt", {31'h0, LS_GNT}, 32'h1);
      chk("t6_if_gnt", {31'h0, IF_GNT}, 32'h0);
      chk("t6_rom_addr", {22'h0, ROM_ADDR}, 32'h100 + k);
      chk("t6_if_rvalid", {31'h0, IF_RVALID}, 32'h0);
      chk("t6_if_rdata", IF_RDATA, 32'h0);
      if (k > 0) chk("t6_ls_rdata", LS_RDATA, 32'hA500_0100 + k - 1);
    end
    nxt(); LS_REQ = 0; #1;
    chk("t6_last_rvalid", {31'h0, LS_RVALID}, 32'h1);
    chk("t6_last_rdata", LS_RDATA, 32'hA500_0103);
    chk("t6_if_rdata_end", IF_RDATA, 32'h0);

    // Test 2: both request every cycle; last winner was LS so IF leads.
    if_n = 0; ls_n = 0;
    prev_if = 1'b0; prev_data = 32'h0;
    for (int j = 0; j < 6; j++) begin
      nxt(); IF_REQ = 1; LS_REQ = 1;
      IF_ADDR = 10'h001 + 10'(if_n); LS_ADDR = 10'h200 + 10'(ls_n); #1;
      exp_if = (j % 2 == 0);
      chk("t2_if_gnt", {31'h0, IF_GNT}, {31'h0, exp_if});
      chk("t2_ls_gnt", {31'h0, LS_GNT}, {31'h0, ~exp_if});
      chk("t2_rom_addr", {22'h0, ROM_ADDR},
          exp_if ? 32'h001 + if_n : 32'h200 + ls_n);
      if (j > 0) begin
        chk("t2_if_rvalid", {31'h0, IF_RVALID}, {31'h0, prev_if});
        chk("t2_ls_rvalid", {31'h0, LS_RVALID}, {31'h0, ~prev_if});
        chk("t2_rdata", prev_if ? IF_RDATA : LS_RDATA, prev_data);
        chk("t2_other_rdata", prev_if ? LS_RDATA : IF_RDATA, 32'h0);
      end
      prev_if   = exp_if;
      prev_data = exp_if ? 32'hA500_0001 + if_n : 32'hA500_0200 + ls_n;
      if (exp_if) if_n++; else ls_n++;
    end
    nxt(); IF_REQ = 0; LS_REQ = 0; #1;
    chk("t2_tail_ls_rvalid", {31'h0, LS_RVALID}, 32'h1);
    chk("t2_tail_rdata", LS_RDATA, 32'hA500_0202);

    // Test 3: LS reads 0x3FF and stalls 3 cycles; IF waits.
    nxt(); LS_REQ = 1; LS_ADDR = 10'h3FF; LS_RREADY = 0; #1;
    chk("t3_ls_gnt", {31'h0, LS_GNT}, 32'h1);
    chk("t3_rom_addr", {22'h0, ROM_ADDR}, 32'h3FF);
    for (int s = 0; s < 3; s++) begin
      nxt(); LS_REQ = 0; IF_REQ = 1; IF_ADDR = 10'h020; #1;
      chk("t3_stall_rvalid", {31'h0, LS_RVALID}, 32'h1);
      chk("t3_stall_rdata", LS_RDATA, 32'hA500_03FF);
      chk("t3_stall_if_gnt", {31'h0, IF_GNT}, 32'h0);
      chk("t3_stall_ls_gnt", {31'h0, LS_GNT}, 32'h0);
      chk("t3_stall_rom_en", {31'h0, ROM_ENABLE}, 32'h0);
    end
    nxt(); LS_RREADY = 1; #1;
    chk("t3_rel_rdata", LS_RDATA, 32'hA500_03FF);
    chk("t3_rel_if_gnt", {31'h0, IF_GNT}, 32'h1);
    chk("t3_rel_rom_addr", {22'h0, ROM_ADDR}, 32'h020);
    nxt(); IF_REQ = 0; #1;
    chk("t3_if_rvalid", {31'h0, IF_RVALID}, 32'h1);
    chk("t3_if_rdata", IF_RDATA, 32'hA500_0020);
    chk("t3_ls_rvalid", {31'h0, LS_RVALID}, 32'h0);

    // Test 5: reset while BUSY, then IF wins first contention.
    nxt(); IF_REQ = 1; IF_ADDR = 10'h030; #1;
    chk("t5_if_gnt", {31'h0, IF_GNT}, 32'h1);
    nxt(); IF_REQ = 0; #1;
    chk("t5_busy_rvalid", {31'h0, IF_RVALID}, 32'h1);
    #1; RST_N = 0; IF_REQ = 1; LS_REQ = 1; #1;
    chk("t5_async_rvalid", {31'h0, IF_RVALID}, 32'h0);
    chk("t5_async_rdata", IF_RDATA, 32'h0);
    chk("t5_async_gnt", {30'h0, LS_GNT, IF_GNT}, 32'h0);
    nxt(); RST_N = 1; IF_ADDR = 10'h040; LS_ADDR = 10'h240; #1;
    chk("t5_first_if_gnt", {31'h0, IF_GNT}, 32'h1);
    chk("t5_first_ls_gnt", {31'h0, LS_GNT}, 32'h0);
    chk("t5_first_rom_addr", {22'h0, ROM_ADDR}, 32'h040);
    nxt(); IF_REQ = 0; LS_REQ = 0; #1;
    chk("t5_resp_rdata", IF_RDATA, 32'hA500_0040);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_rom_access_arbiter
